// File: rtl/instr_mem_responder.sv
`timescale 1ns/1ps
// Responder side of an instruction-fetch req/gnt/rvalid interface: grants requests under an
// outstanding limit and returns word reads in order, LATENCY cycles after grant, with flush and preload.
module instr_mem_responder #(
  parameter int          DEPTH_WORDS     = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_WORD        = 32'h0000_0013,
  localparam int         AW              = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_req_in,
  input  logic [31:0]   instr_addr_in,
  input  logic          flush_in,
  output logic          gnt_out,
  output logic          instr_rvalid_out,
  output logic [31:0]   instr_rdata_out,
  output logic          instr_err_out,
  input  logic          load_we_in,
  input  logic [AW-1:0] load_addr_in,
  input  logic [31:0]   load_data_in
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]        mem_q [DEPTH_WORDS];
  logic [LATENCY-1:0] pv_q, pv_d;
  logic [LATENCY-1:0] pe_q, pe_d;
  logic [31:0]        pd_q [LATENCY];
  logic [31:0]        pd_d [LATENCY];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               grant_s;
  logic               req_err_s;
  logic [AW-1:0]      req_idx_s;
  logic [31:0]        req_data_s;

  // Decode the request and decide whether it is granted this cycle.
  always_comb begin
    req_idx_s = instr_addr_in[AW+1:2];
    req_err_s = (instr_addr_in[1:0] != 2'b00) || (instr_addr_in[31:AW+2] != '0);
    if (req_err_s) begin
      req_data_s = NOP_WORD;
    end else begin
      req_data_s = mem_q[req_idx_s];
    end
    grant_s = rst_n & instr_req_in & ~flush_in & (cnt_q < CW'(MAX_OUTSTANDING));
  end

  // Response pipeline; the last stage doubles as the output register and holds data between responses.
  always_comb begin
    pv_d    = '0;
    pe_d    = '0;
    pv_d[0] = grant_s;
    pe_d[0] = req_err_s;
    pd_d[0] = req_data_s;
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1] & ~flush_in;
      pe_d[i] = pe_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    pe_d[LATENCY-1] = pv_d[LATENCY-1] ? pe_d[LATENCY-1] : pe_q[LATENCY-1];
    pd_d[LATENCY-1] = pv_d[LATENCY-1] ? pd_d[LATENCY-1] : pd_q[LATENCY-1];
  end

  // Outstanding count: a response stops counting on the edge it moves onto the outputs.
  always_comb begin
    if (flush_in) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(grant_s) - CW'(pv_d[LATENCY-1]);
    end
  end

  // Pipeline and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q  <= '0;
      pe_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q  <= pv_d;
      pe_q  <= pe_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < LATENCY; i++) begin
        pd_q[i] <= pd_d[i];
      end
    end
  end

  // Preload port; storage is deliberately not reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (load_we_in) begin
      mem_q[load_addr_in] <= load_data_in;
    end
  end

  assign gnt_out          = grant_s;
  assign instr_rvalid_out = pv_q[LATENCY-1];
  assign instr_err_out    = pe_q[LATENCY-1];
  assign instr_rdata_out  = pd_q[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_responder.sv
`timescale 1ns/1ps
// Bench for instr_mem_responder (LATENCY=3, MAX_OUTSTANDING=2): directed scenarios with literal
// expectations plus a randomized run, all outputs compared every cycle against a queue-based model.
module tb_instr_mem_responder;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 3;
  localparam int          MAXO  = 2;
  localparam int          AW    = 10;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req = 1'b0;
  logic          flush = 1'b0;
  logic          load_we = 1'b0;
  logic [31:0]   addr = 32'd0;
  logic [31:0]   load_data = 32'd0;
  logic [AW-1:0] load_addr = '0;
  logic          gnt, rvalid, err;
  logic [31:0]   rdata;

  int tests_run = 0;
  int tests_failed = 0;

  instr_mem_responder #(
    .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_req_in(req), .instr_addr_in(addr), .flush_in(flush),
    .gnt_out(gnt), .instr_rvalid_out(rvalid), .instr_rdata_out(rdata), .instr_err_out(err),
    .load_we_in(load_we), .load_addr_in(load_addr), .load_data_in(load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] a_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Reference model: each granted request is a queued response tagged with the edge after which it shows.
  typedef struct { int due; logic err; logic [31:0] data; } resp_t;
  resp_t       q[$];
  logic [31:0] mmem [DEPTH];
  int          edge_n = 0;
  logic        m_v = 1'b0;
  logic        m_e = 1'b0;
  logic [31:0] m_d = 32'd0;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a % 32'd4 != 32'd0) || (a >= 32'(4 * DEPTH));
  endfunction

  always @(posedge clk) begin
    if (load_we) mmem[load_addr] <= load_data;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_v = 1'b0;
      m_e = 1'b0;
      m_d = 32'd0;
    end else begin : step
      logic  g;
      resp_t r;
      g = req && !flush && (q.size() < MAXO);
      if (flush) begin
        q.delete();
        m_v = 1'b0;
      end else begin
        if (g) begin
          r.due  = edge_n + LAT - 1;
          r.err  = addr_bad(addr);
          r.data = r.err ? NOP : mmem[int'(addr >> 2)];
          q.push_back(r);
        end
        if (q.size() > 0 && q[0].due == edge_n) begin
          r   = q.pop_front();
          m_v = 1'b1;
          m_e = r.err;
          m_d = r.data;
        end else begin
          m_v = 1'b0;
        end
      end
      edge_n++;
    end
  end

  always @(negedge clk) begin
    chk("gnt", gnt, rst_n && req && !flush && (q.size() < MAXO));
    chk("rvalid", rvalid, m_v);
    chk("rdata", rdata, m_d);
    chk("err", err, m_e);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic single_req(input logic [31:0] a, input logic e_err, input logic [31:0] e_data);
    req  = 1'b1;
    addr = a;
    #1 chk("sr_gnt", gnt, 1'b1);
    next_cycle();
    req     = 1'b0;
    load_we = 1'b0;
    repeat (2) begin
      #1 chk("sr_early_rvalid", rvalid, 1'b0);
      next_cycle();
    end
    #1;
    chk("sr_rvalid", rvalid, 1'b1);
    chk("sr_err", err, e_err);
    chk("sr_rdata", rdata, e_data);
    next_cycle();
    #1;
    chk("sr_single_pulse", rvalid, 1'b0);
    chk("sr_rdata_hold", rdata, e_data);
    next_cycle();
  endtask

  bit eg [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int ed [9] = '{-1, -1, -1, 0, 1, -1, 2, 3, -1};
  int granted;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 64; i++) begin
      load_we   = 1'b1;
      load_addr = AW'(i);
      load_data = a_word(i);
      next_cycle();
    end
    load_we = 1'b0;

    // Held request: two grants, stall, grant re-opens as each response moves out.
    granted = 0;
    for (int c = 0; c < 9; c++) begin
      req  = (granted < 4);
      addr = 32'(4 * granted);
      #1;
      chk("t2_gnt", gnt, eg[c]);
      chk("t2_rvalid", rvalid, ed[c] >= 0);
      if (ed[c] >= 0) chk("t2_rdata", rdata, a_word(ed[c]));
      if (eg[c]) granted++;
      next_cycle();
    end
    req = 1'b0;

    single_req(32'h0000_0002, 1'b1, 32'h0000_0013);
    single_req(32'h0000_1000, 1'b1, 32'h0000_0013);
    single_req(32'h0000_0000, 1'b0, 32'hC0DE_0000);

    // Flush with two responses in flight.
    req  = 1'b1;
    addr = 32'd0;
    #1 chk("t4_gnt0", gnt, 1'b1);
    next_cycle();
    addr = 32'd4;
    #1 chk("t4_gnt1", gnt, 1'b1);
    next_cycle();
    addr  = 32'd8;
    flush = 1'b1;
    #1 chk("t4_gnt_flush", gnt, 1'b0);
    next_cycle();
    flush = 1'b0;
    req   = 1'b0;
    repeat (5) begin
      #1 chk("t4_no_rvalid", rvalid, 1'b0);
      next_cycle();
    end
    single_req(32'd8, 1'b0, 32'hC0DE_0002);

    // Read and load of the same word on one edge.
    load_we   = 1'b1;
    load_addr = AW'(4);
    load_data = 32'hDEAD_BEEF;
    single_req(32'h0000_0010, 1'b0, 32'hC0DE_0004);
    single_req(32'h0000_0010, 1'b0, 32'hDEAD_BEEF);

    // Reset with two outstanding.
    req  = 1'b1;
    addr = 32'd0;
    #1 chk("t6_gnt0", gnt, 1'b1);
    next_cycle();
    addr = 32'd4;
    #1 chk("t6_gnt1", gnt, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("t6_gnt_rst", gnt, 1'b0);
    chk("t6_rvalid_rst", rvalid, 1'b0);
    chk("t6_rdata_rst", rdata, 32'd0);
    chk("t6_err_rst", err, 1'b0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    req   = 1'b0;
    repeat (6) begin
      #1 chk("t6_no_rvalid", rvalid, 1'b0);
      next_cycle();
    end
    single_req(32'd12, 1'b0, 32'hC0DE_0003);

    // Randomized traffic, checked by the per-cycle model comparison.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      req   = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0:       addr = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(1, 3));
        1:       addr = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
        default: addr = 32'($urandom_range(0, 63)) * 32'd4;
      endcase
      load_we   = ($urandom_range(0, 4) == 0);
      load_addr = AW'($urandom_range(0, 63));
      load_data = $urandom;
      next_cycle();
    end
    rst_n   = 1'b1;
    req     = 1'b0;
    flush   = 1'b0;
    load_we = 1'b0;
    repeat (6) next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
